// File: rtl/uv_gpio_filt.sv
// ---------------------------------------------------------------------------
// uv_gpio_filt
// Per-bit GPIO input conditioning: two-flop synchroniser, optional debounce
// filter, and edge/level interrupt pending flags with write-1-to-clear.
//
// Build option: define GPIO_DEBOUNCE_EN to include the per-bit debounce
// counters. Without it, cfg_dbc_en / cfg_dbc_thr are accepted but ignored
// and every bit follows the synchroniser output directly.
// ---------------------------------------------------------------------------
module uv_gpio_filt #(
    parameter int IO_NUM = 32,
    parameter int DBC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IO_NUM-1:0] gpio_in,
    input  logic [IO_NUM-1:0] cfg_dbc_en,
    input  logic [DBC_W-1:0]  cfg_dbc_thr,
    input  logic [IO_NUM-1:0] cfg_rise_en,
    input  logic [IO_NUM-1:0] cfg_fall_en,
    input  logic [IO_NUM-1:0] cfg_lvl_hi_en,
    input  logic [IO_NUM-1:0] cfg_lvl_lo_en,
    input  logic [IO_NUM-1:0] irq_clr,
    output logic [IO_NUM-1:0] gpio_val,
    output logic [IO_NUM-1:0] irq_pend,
    output logic              irq
);

    logic [IO_NUM-1:0] sync1;
    logic [IO_NUM-1:0] sync2;
    logic [IO_NUM-1:0] val_nxt;
    logic [IO_NUM-1:0] rise_evt;
    logic [IO_NUM-1:0] fall_evt;
    logic [IO_NUM-1:0] lvl_evt;
    logic [IO_NUM-1:0] pend_nxt;

    // Two-flop synchroniser for the asynchronous pad inputs.
    // NOTE: non-blocking assignments make sync2 capture the old sync1, so the
    // two stages are real flops rather than collapsing into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [DBC_W-1:0] cnt     [IO_NUM];
    logic [DBC_W-1:0] cnt_nxt [IO_NUM];

    // Debounce decision: a bit only follows sync2 once the mismatch has
    // persisted past the threshold; any agreement restarts the count.
    always_comb begin
        for (int i = 0; i < IO_NUM; i++) begin
            // NOTE: defaults first so every path assigns both outputs and
            // no latch is inferred.
            val_nxt[i] = gpio_val[i];
            cnt_nxt[i] = '0;
            if (!cfg_dbc_en[i]) begin
                val_nxt[i] = sync2[i];
            end else if (sync2[i] != gpio_val[i]) begin
                // >= (not ==) so a threshold lowered below the running count
                // still releases on the next edge instead of wrapping.
                if (cnt[i] >= cfg_dbc_thr) begin
                    val_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + DBC_W'(1);
                end
            end
        end
    end

    // Debounce counter registers.
    // NOTE: the counter array is a set of flops, not a RAM, so it is reset
    // explicitly; a reset mid-count must discard the partial count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IO_NUM; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IO_NUM; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end
`else
    logic unused_dbc_cfg;

    // Debounce compiled out: the filtered value simply tracks sync2.
    assign val_nxt        = sync2;
    assign unused_dbc_cfg = ^{cfg_dbc_en, cfg_dbc_thr};
`endif

    // Filtered value register.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_val <= '0;
        end else begin
            gpio_val <= val_nxt;
        end
    end

    // Interrupt set/clear. Edge events look at the transition happening on
    // this edge so the flag sets together with gpio_val; level events look at
    // the current gpio_val. A clear beats a level source for one cycle (so the
    // drop is visible) but never beats an edge event.
    always_comb begin
        rise_evt = val_nxt & ~gpio_val & cfg_rise_en;
        fall_evt = ~val_nxt & gpio_val & cfg_fall_en;
        lvl_evt  = (gpio_val & cfg_lvl_hi_en) | (~gpio_val & cfg_lvl_lo_en);
        pend_nxt = rise_evt | fall_evt | (~irq_clr & (irq_pend | lvl_evt));
    end

    // Pending flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_pend <= '0;
        end else begin
            irq_pend <= pend_nxt;
        end
    end

    assign irq = |irq_pend;

endmodule

// File: tb/tb_uv_gpio_filt.sv
// ---------------------------------------------------------------------------
// tb_uv_gpio_filt
// Directed self-checking bench for uv_gpio_filt (IO_NUM=32, DBC_W=16).
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// so every check observes the state produced by the edge just passed.
// ---------------------------------------------------------------------------
module tb_uv_gpio_filt;

    localparam int IO_NUM = 32;
    localparam int DBC_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [IO_NUM-1:0] gpio_in;
    logic [IO_NUM-1:0] cfg_dbc_en;
    logic [DBC_W-1:0]  cfg_dbc_thr;
    logic [IO_NUM-1:0] cfg_rise_en;
    logic [IO_NUM-1:0] cfg_fall_en;
    logic [IO_NUM-1:0] cfg_lvl_hi_en;
    logic [IO_NUM-1:0] cfg_lvl_lo_en;
    logic [IO_NUM-1:0] irq_clr;
    logic [IO_NUM-1:0] gpio_val;
    logic [IO_NUM-1:0] irq_pend;
    logic              irq;

    int checks = 0;
    int errors = 0;

    uv_gpio_filt #(.IO_NUM(IO_NUM), .DBC_W(DBC_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .gpio_in       (gpio_in),
        .cfg_dbc_en    (cfg_dbc_en),
        .cfg_dbc_thr   (cfg_dbc_thr),
        .cfg_rise_en   (cfg_rise_en),
        .cfg_fall_en   (cfg_fall_en),
        .cfg_lvl_hi_en (cfg_lvl_hi_en),
        .cfg_lvl_lo_en (cfg_lvl_lo_en),
        .irq_clr       (irq_clr),
        .gpio_val      (gpio_val),
        .irq_pend      (irq_pend),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        gpio_in       = '1;
        cfg_dbc_en    = '0;
        cfg_dbc_thr   = '0;
        cfg_rise_en   = '1;
        cfg_fall_en   = '1;
        cfg_lvl_hi_en = '1;
        cfg_lvl_lo_en = '1;
        irq_clr       = '0;
        repeat (3) tick();
        checks++;
        if (gpio_val !== '0) begin
            errors++;
            $display("FAIL reset_val: got %h expected %h", gpio_val, 32'h0);
        end
        checks++;
        if (irq_pend !== '0) begin
            errors++;
            $display("FAIL reset_pend: got %h expected %h", irq_pend, 32'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        gpio_in       = '0;
        cfg_rise_en   = '0;
        cfg_fall_en   = '0;
        cfg_lvl_hi_en = '0;
        cfg_lvl_lo_en = '0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (irq_pend !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: got %h expected %h", irq_pend, 32'h0);
        end
    endtask

    // Bit 0 rises: sampled at edge A, visible after A+2 with the rise flag.
    task automatic test_rise_latency();
        cfg_rise_en = 32'h1;
        gpio_in     = 32'h1;
        tick();
        checks++;
        if (gpio_val !== 32'h0) begin
            errors++;
            $display("FAIL rise_lat_e0: got %h expected %h", gpio_val, 32'h0);
        end
        tick();
        checks++;
        if (gpio_val !== 32'h0 || irq_pend !== 32'h0) begin
            errors++;
            $display("FAIL rise_lat_e1: got val=%h pend=%h expected val=0 pend=0", gpio_val, irq_pend);
        end
        tick();
        checks++;
        if (gpio_val !== 32'h1) begin
            errors++;
            $display("FAIL rise_lat_e2_val: got %h expected %h", gpio_val, 32'h1);
        end
        checks++;
        if (irq_pend !== 32'h1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL rise_pend: got pend=%h irq=%b expected pend=1 irq=1", irq_pend, irq);
        end
        irq_clr = 32'h1;
        tick();
        irq_clr = '0;
        checks++;
        if (irq_pend !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rise_clr: got pend=%h irq=%b expected pend=0 irq=0", irq_pend, irq);
        end
        tick();
        checks++;
        if (irq_pend !== 32'h0) begin
            errors++;
            $display("FAIL rise_clr_hold: got %h expected %h", irq_pend, 32'h0);
        end
        cfg_rise_en = '0;
    endtask

    // Bit 7 falls in the same cycle it is cleared: the set must win.
    task automatic test_fall_set_wins();
        gpio_in = 32'h81;
        repeat (3) tick();
        checks++;
        if (gpio_val !== 32'h81 || irq_pend !== 32'h0) begin
            errors++;
            $display("FAIL fall_setup: got val=%h pend=%h expected val=81 pend=0", gpio_val, irq_pend);
        end
        cfg_fall_en = 32'h80;
        gpio_in     = 32'h01;
        tick();
        tick();
        irq_clr = 32'h80;
        tick();
        irq_clr = '0;
        checks++;
        if (gpio_val !== 32'h01) begin
            errors++;
            $display("FAIL fall_val: got %h expected %h", gpio_val, 32'h01);
        end
        checks++;
        if (irq_pend !== 32'h80) begin
            errors++;
            $display("FAIL fall_set_wins: got %h expected %h", irq_pend, 32'h80);
        end
        irq_clr = 32'h80;
        tick();
        irq_clr = '0;
        checks++;
        if (irq_pend !== 32'h0) begin
            errors++;
            $display("FAIL fall_clr: got %h expected %h", irq_pend, 32'h0);
        end
        cfg_fall_en = '0;
    endtask

    // Bit 5 low-level source: clear drops the flag for one cycle only.
    task automatic test_level_clear();
        cfg_lvl_lo_en = 32'h20;
        tick();
        checks++;
        if (irq_pend !== 32'h20 || irq !== 1'b1) begin
            errors++;
            $display("FAIL lvl_set: got pend=%h irq=%b expected pend=20 irq=1", irq_pend, irq);
        end
        irq_clr = 32'h20;
        tick();
        irq_clr = '0;
        checks++;
        if (irq_pend !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL lvl_drop: got pend=%h irq=%b expected pend=0 irq=0", irq_pend, irq);
        end
        tick();
        checks++;
        if (irq_pend !== 32'h20 || irq !== 1'b1) begin
            errors++;
            $display("FAIL lvl_reset: got pend=%h irq=%b expected pend=20 irq=1", irq_pend, irq);
        end
        cfg_lvl_lo_en = '0;
        tick();
        checks++;
        if (irq_pend !== 32'h20) begin
            errors++;
            $display("FAIL lvl_disable_keeps: got %h expected %h", irq_pend, 32'h20);
        end
        irq_clr = 32'h20;
        tick();
        irq_clr = '0;
        tick();
        checks++;
        if (irq_pend !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL lvl_final_clr: got pend=%h irq=%b expected pend=0 irq=0", irq_pend, irq);
        end
    endtask

    // Bit 9 high-level source follows the registered value, one edge later.
    task automatic test_level_hi();
        cfg_lvl_hi_en = 32'h200;
        tick();
        checks++;
        if (irq_pend !== 32'h0) begin
            errors++;
            $display("FAIL lvlhi_idle: got %h expected %h", irq_pend, 32'h0);
        end
        gpio_in = 32'h201;
        repeat (3) tick();
        checks++;
        if (gpio_val !== 32'h201 || irq_pend !== 32'h0) begin
            errors++;
            $display("FAIL lvlhi_val: got val=%h pend=%h expected val=201 pend=0", gpio_val, irq_pend);
        end
        tick();
        checks++;
        if (irq_pend !== 32'h200) begin
            errors++;
            $display("FAIL lvlhi_set: got %h expected %h", irq_pend, 32'h200);
        end
        cfg_lvl_hi_en = '0;
        irq_clr       = 32'h200;
        tick();
        irq_clr = '0;
        checks++;
        if (irq_pend !== 32'h0) begin
            errors++;
            $display("FAIL lvlhi_clr: got %h expected %h", irq_pend, 32'h0);
        end
    endtask

`ifdef GPIO_DEBOUNCE_EN
    // Bit 3 with threshold 4: a 3-cycle pulse is rejected, a held level
    // is accepted 5 edges after sync2 rises.
    task automatic test_debounce();
        cfg_dbc_en  = 32'h8;
        cfg_dbc_thr = 16'd4;
        cfg_rise_en = 32'h8;
        gpio_in     = 32'h209;
        repeat (3) tick();
        gpio_in = 32'h201;
        repeat (10) tick();
        checks++;
        if (gpio_val[3] !== 1'b0 || irq_pend[3] !== 1'b0) begin
            errors++;
            $display("FAIL dbc_glitch: got val3=%b pend3=%b expected 0 0", gpio_val[3], irq_pend[3]);
        end
        gpio_in = 32'h209;
        repeat (6) tick();
        checks++;
        if (gpio_val[3] !== 1'b0) begin
            errors++;
            $display("FAIL dbc_early: got %b expected 0", gpio_val[3]);
        end
        tick();
        checks++;
        if (gpio_val[3] !== 1'b1 || irq_pend !== 32'h8) begin
            errors++;
            $display("FAIL dbc_accept: got val3=%b pend=%h expected 1 8", gpio_val[3], irq_pend);
        end
        // Partial count on bit 2 (thr 8) before the reset test wipes it.
        cfg_dbc_en  = 32'hC;
        cfg_dbc_thr = 16'd8;
        gpio_in     = 32'h20D;
        repeat (5) tick();
        cfg_rise_en = '0;
        cfg_dbc_en  = '0;
    endtask
`endif

    // Force every flag, then reset: all outputs return to 0 in one edge.
    task automatic test_reset_all();
        cfg_lvl_hi_en = '1;
        cfg_lvl_lo_en = '1;
        tick();
        checks++;
        if (irq_pend !== 32'hFFFF_FFFF || irq !== 1'b1) begin
            errors++;
            $display("FAIL all_pend: got pend=%h irq=%b expected ffffffff 1", irq_pend, irq);
        end
        rst           = 1'b1;
        gpio_in       = 32'h1;
        cfg_lvl_hi_en = '0;
        cfg_lvl_lo_en = '0;
        cfg_rise_en   = 32'h1;
        tick();
        checks++;
        if (gpio_val !== 32'h0 || irq_pend !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got val=%h pend=%h irq=%b expected 0 0 0", gpio_val, irq_pend, irq);
        end
        tick();
        checks++;
        if (irq_pend !== 32'h0) begin
            errors++;
            $display("FAIL rst_hold: got %h expected %h", irq_pend, 32'h0);
        end
    endtask

    // Pad held high through reset gives one rising event after release.
    // In the default build the debounce config is ignored entirely.
    task automatic test_hold_through_reset();
`ifdef GPIO_DEBOUNCE_EN
        cfg_dbc_en = '0;
`else
        cfg_dbc_en = '1;
`endif
        cfg_dbc_thr = 16'd100;
        rst         = 1'b0;
        tick();
        tick();
        checks++;
        if (gpio_val !== 32'h0 || irq_pend !== 32'h0) begin
            errors++;
            $display("FAIL hold_e1: got val=%h pend=%h expected 0 0", gpio_val, irq_pend);
        end
        tick();
        checks++;
        if (gpio_val !== 32'h1 || irq_pend !== 32'h1) begin
            errors++;
            $display("FAIL hold_rise: got val=%h pend=%h expected 1 1", gpio_val, irq_pend);
        end
        irq_clr = 32'h1;
        tick();
        irq_clr = '0;
        repeat (2) tick();
        checks++;
        if (irq_pend !== 32'h0 || gpio_val !== 32'h1) begin
            errors++;
            $display("FAIL hold_single: got val=%h pend=%h expected 1 0", gpio_val, irq_pend);
        end
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_fall_set_wins();
        test_level_clear();
        test_level_hi();
`ifdef GPIO_DEBOUNCE_EN
        test_debounce();
`endif
        test_reset_all();
        test_hold_through_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
